// File: rtl/ip_sdram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ip_sdram_arbiter_pkg
// Brief    : State/owner encodings, defaults and byte-lane helper for the
//            SDRAM port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package ip_sdram_arbiter_pkg;

    localparam int REFRESH_INTERVAL_DEFAULT = 320;
    localparam int REFRESH_CNT_W_DEFAULT    = 9;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2,
        S_WAIT   = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_RFSH  = 2'd1,
        OWN_VIDEO = 2'd2,
        OWN_CPU   = 2'd3
    } arb_owner_t;

    function automatic logic [7:0] byte_select(input logic [31:0] word,
                                               input logic [1:0]  lane);
        return word[8*lane +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/ip_sdram_refresh_timer.sv
`default_nettype none
// ============================================================================
// Module   : ip_sdram_refresh_timer
// Brief    : Free-running refresh interval counter with a single-entry
//            "refresh owed" flag.
// Revision : 1.0 - initial release
// ============================================================================
module ip_sdram_refresh_timer
    import ip_sdram_arbiter_pkg::*;
#(
    parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEFAULT,
    parameter int REFRESH_CNT_W    = REFRESH_CNT_W_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic hold,
    input  logic clear,
    output logic rfsh_pend
);

    localparam logic [REFRESH_CNT_W-1:0] c_last_cnt = REFRESH_CNT_W'(REFRESH_INTERVAL - 1);

    logic [REFRESH_CNT_W-1:0] r_count_q, w_count_d;
    logic                     r_pend_q,  w_pend_d;

    always_comb begin
        w_count_d = r_count_q;
        w_pend_d  = r_pend_q;
        if (hold) begin
            w_count_d = '0;
            w_pend_d  = 1'b0;
        end else begin
            if (clear) begin
                w_pend_d = 1'b0;
            end
            // A wrap while a refresh is still owed just leaves the flag set.
            if (r_count_q == c_last_cnt) begin
                w_count_d = '0;
                w_pend_d  = 1'b1;
            end else begin
                w_count_d = r_count_q + REFRESH_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count_q <= '0;
            r_pend_q  <= 1'b0;
        end else begin
            r_count_q <= w_count_d;
            r_pend_q  <= w_pend_d;
        end
    end

    assign rfsh_pend = r_pend_q;

endmodule
`default_nettype wire

// File: rtl/ip_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ip_sdram_arbiter
// Brief    : Shares one ip_sdram port between refresh, video fetch and a CPU
//            window. Optional macro SDRAM_ARB_CPU_FAIR_EN lets a pending CPU
//            request win the arbitration that follows a video grant.
// Revision : 1.0 - initial release
// ============================================================================
module ip_sdram_arbiter
    import ip_sdram_arbiter_pkg::*;
#(
    parameter int REFRESH_INTERVAL = REFRESH_INTERVAL_DEFAULT,
    parameter int REFRESH_CNT_W    = REFRESH_CNT_W_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        video_req,
    input  logic [22:0] video_address,
    output logic        video_ack,
    output logic [31:0] video_rdata,
    output logic        video_rdata_en,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [22:0] cpu_address,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ack,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_rdata_en,
    input  logic        sdram_init_busy,
    input  logic        sdram_busy,
    input  logic [31:0] sdram_rdata,
    input  logic        sdram_rdata_en,
    output logic        mreq_n,
    output logic        wr_n,
    output logic        rd_n,
    output logic        rfsh_n,
    output logic [22:0] address,
    output logic [7:0]  wdata
);

    arb_state_t  r_state_q,          w_state_d;
    arb_owner_t  r_owner_q,          w_owner_d;
    logic        r_own_wr_q,         w_own_wr_d;
    logic [1:0]  r_lane_q,           w_lane_d;
    logic        r_data_done_q,      w_data_done_d;
    logic        r_mreq_n_q,         w_mreq_n_d;
    logic        r_wr_n_q,           w_wr_n_d;
    logic        r_rd_n_q,           w_rd_n_d;
    logic        r_rfsh_n_q,         w_rfsh_n_d;
    logic [22:0] r_address_q,        w_address_d;
    logic [7:0]  r_wdata_q,          w_wdata_d;
    logic        r_video_ack_q,      w_video_ack_d;
    logic        r_cpu_ack_q,        w_cpu_ack_d;
    logic [31:0] r_video_rdata_q,    w_video_rdata_d;
    logic        r_video_rdata_en_q, w_video_rdata_en_d;
    logic [7:0]  r_cpu_rdata_q,      w_cpu_rdata_d;
    logic        r_cpu_rdata_en_q,   w_cpu_rdata_en_d;

    logic w_rfsh_pend;
    logic w_can_grant;
    logic w_grant;
    logic w_cpu_first;
    logic w_pick_video;
    logic w_pick_cpu;
    logic w_rd_owner;
    logic w_rd_ret;

    ip_sdram_refresh_timer #(
        .REFRESH_INTERVAL (REFRESH_INTERVAL),
        .REFRESH_CNT_W    (REFRESH_CNT_W)
    ) u_refresh_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .hold      (sdram_init_busy),
        .clear     (w_grant && w_rfsh_pend),
        .rfsh_pend (w_rfsh_pend)
    );

    assign w_can_grant  = (r_state_q == S_IDLE) && !sdram_init_busy && !sdram_busy;
    assign w_grant      = w_can_grant && (w_rfsh_pend || video_req || cpu_req);
    assign w_pick_video = !w_rfsh_pend && video_req && !w_cpu_first;
    assign w_pick_cpu   = !w_rfsh_pend && !w_pick_video && cpu_req;

`ifdef SDRAM_ARB_CPU_FAIR_EN
    // Remembers that video won last time so a waiting CPU gets the next slot.
    logic r_last_video_q, w_last_video_d;

    always_comb begin
        w_last_video_d = r_last_video_q;
        if (w_grant && w_pick_video) begin
            w_last_video_d = 1'b1;
        end else if (w_grant && w_pick_cpu) begin
            w_last_video_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last_video_q <= 1'b0;
        end else begin
            r_last_video_q <= w_last_video_d;
        end
    end

    assign w_cpu_first = r_last_video_q && cpu_req;
`else
    assign w_cpu_first = 1'b0;
`endif

    assign w_rd_owner = (r_owner_q == OWN_VIDEO) || ((r_owner_q == OWN_CPU) && !r_own_wr_q);
    assign w_rd_ret   = sdram_rdata_en && w_rd_owner &&
                        ((r_state_q == S_SETTLE) || (r_state_q == S_WAIT));

    always_comb begin
        w_state_d          = r_state_q;
        w_owner_d          = r_owner_q;
        w_own_wr_d         = r_own_wr_q;
        w_lane_d           = r_lane_q;
        w_data_done_d      = r_data_done_q;
        w_mreq_n_d         = 1'b1;
        w_wr_n_d           = 1'b1;
        w_rd_n_d           = 1'b1;
        w_rfsh_n_d         = 1'b1;
        w_address_d        = r_address_q;
        w_wdata_d          = r_wdata_q;
        w_video_ack_d      = 1'b0;
        w_cpu_ack_d        = 1'b0;
        w_video_rdata_d    = r_video_rdata_q;
        w_video_rdata_en_d = 1'b0;
        w_cpu_rdata_d      = r_cpu_rdata_q;
        w_cpu_rdata_en_d   = 1'b0;

        case (r_state_q)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_d     = S_ISSUE;
                    w_mreq_n_d    = 1'b0;
                    w_data_done_d = 1'b0;
                    w_own_wr_d    = 1'b0;
                    if (w_rfsh_pend) begin
                        w_owner_d  = OWN_RFSH;
                        w_rfsh_n_d = 1'b0;
                    end else if (w_pick_video) begin
                        w_owner_d     = OWN_VIDEO;
                        w_rd_n_d      = 1'b0;
                        w_address_d   = video_address;
                        w_video_ack_d = 1'b1;
                    end else begin
                        w_owner_d   = OWN_CPU;
                        w_own_wr_d  = cpu_wr;
                        w_lane_d    = cpu_address[1:0];
                        w_address_d = cpu_address;
                        w_cpu_ack_d = 1'b1;
                        if (cpu_wr) begin
                            w_wr_n_d  = 1'b0;
                            w_wdata_d = cpu_wdata;
                        end else begin
                            w_rd_n_d = 1'b0;
                        end
                    end
                end
            end
            S_ISSUE:  w_state_d = S_SETTLE;
            S_SETTLE: w_state_d = S_WAIT;
            S_WAIT: begin
                // Data arriving in the same cycle busy drops also completes a read.
                if (!sdram_busy && (!w_rd_owner || r_data_done_q || w_rd_ret)) begin
                    w_state_d = S_IDLE;
                    w_owner_d = OWN_NONE;
                end
            end
            default: w_state_d = S_IDLE;
        endcase

        if (w_rd_ret) begin
            w_data_done_d = 1'b1;
            if (r_owner_q == OWN_VIDEO) begin
                w_video_rdata_d    = sdram_rdata;
                w_video_rdata_en_d = 1'b1;
            end else begin
                w_cpu_rdata_d    = byte_select(sdram_rdata, r_lane_q);
                w_cpu_rdata_en_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state_q          <= S_IDLE;
            r_owner_q          <= OWN_NONE;
            r_own_wr_q         <= 1'b0;
            r_lane_q           <= 2'd0;
            r_data_done_q      <= 1'b0;
            r_mreq_n_q         <= 1'b1;
            r_wr_n_q           <= 1'b1;
            r_rd_n_q           <= 1'b1;
            r_rfsh_n_q         <= 1'b1;
            r_address_q        <= '0;
            r_wdata_q          <= '0;
            r_video_ack_q      <= 1'b0;
            r_cpu_ack_q        <= 1'b0;
            r_video_rdata_q    <= '0;
            r_video_rdata_en_q <= 1'b0;
            r_cpu_rdata_q      <= '0;
            r_cpu_rdata_en_q   <= 1'b0;
        end else begin
            r_state_q          <= w_state_d;
            r_owner_q          <= w_owner_d;
            r_own_wr_q         <= w_own_wr_d;
            r_lane_q           <= w_lane_d;
            r_data_done_q      <= w_data_done_d;
            r_mreq_n_q         <= w_mreq_n_d;
            r_wr_n_q           <= w_wr_n_d;
            r_rd_n_q           <= w_rd_n_d;
            r_rfsh_n_q         <= w_rfsh_n_d;
            r_address_q        <= w_address_d;
            r_wdata_q          <= w_wdata_d;
            r_video_ack_q      <= w_video_ack_d;
            r_cpu_ack_q        <= w_cpu_ack_d;
            r_video_rdata_q    <= w_video_rdata_d;
            r_video_rdata_en_q <= w_video_rdata_en_d;
            r_cpu_rdata_q      <= w_cpu_rdata_d;
            r_cpu_rdata_en_q   <= w_cpu_rdata_en_d;
        end
    end

    assign mreq_n         = r_mreq_n_q;
    assign wr_n           = r_wr_n_q;
    assign rd_n           = r_rd_n_q;
    assign rfsh_n         = r_rfsh_n_q;
    assign address        = r_address_q;
    assign wdata          = r_wdata_q;
    assign video_ack      = r_video_ack_q;
    assign cpu_ack        = r_cpu_ack_q;
    assign video_rdata    = r_video_rdata_q;
    assign video_rdata_en = r_video_rdata_en_q;
    assign cpu_rdata      = r_cpu_rdata_q;
    assign cpu_rdata_en   = r_cpu_rdata_en_q;

endmodule
`default_nettype wire

// File: tb/tb_ip_sdram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_sdram_arbiter
// Brief    : Directed self-checking bench for ip_sdram_arbiter with a small
//            behavioural ip_sdram responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ip_sdram_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        video_req;
    logic [22:0] video_address;
    logic        video_ack;
    logic [31:0] video_rdata;
    logic        video_rdata_en;
    logic        cpu_req;
    logic        cpu_wr;
    logic [22:0] cpu_address;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdata_en;
    logic        sdram_init_busy;
    logic        sdram_busy     = 1'b0;
    logic [31:0] sdram_rdata    = 32'h0;
    logic        sdram_rdata_en = 1'b0;
    logic        mreq_n, wr_n, rd_n, rfsh_n;
    logic [22:0] address;
    logic [7:0]  wdata;

    int          passed = 0;
    int          fails  = 0;
    int          total  = 0;
    int          cyc    = 0;
    int          rel0   = 0;

    logic [31:0] model_rdata = 32'h0;
    logic        model_hold  = 1'b0;
    int          model_lat   = 2;
    int          m_cnt       = 0;
    logic        m_rd        = 1'b0;

    ip_sdram_arbiter dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .video_req       (video_req),
        .video_address   (video_address),
        .video_ack       (video_ack),
        .video_rdata     (video_rdata),
        .video_rdata_en  (video_rdata_en),
        .cpu_req         (cpu_req),
        .cpu_wr          (cpu_wr),
        .cpu_address     (cpu_address),
        .cpu_wdata       (cpu_wdata),
        .cpu_ack         (cpu_ack),
        .cpu_rdata       (cpu_rdata),
        .cpu_rdata_en    (cpu_rdata_en),
        .sdram_init_busy (sdram_init_busy),
        .sdram_busy      (sdram_busy),
        .sdram_rdata     (sdram_rdata),
        .sdram_rdata_en  (sdram_rdata_en),
        .mreq_n          (mreq_n),
        .wr_n            (wr_n),
        .rd_n            (rd_n),
        .rfsh_n          (rfsh_n),
        .address         (address),
        .wdata           (wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // ip_sdram responder: busy from the command cycle, read data model_lat
    // negedges later together with busy dropping.
    always @(negedge clk) begin
        sdram_rdata_en = 1'b0;
        if (m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0 && m_rd) begin
                sdram_rdata    = model_rdata;
                sdram_rdata_en = 1'b1;
            end
        end
        if (mreq_n === 1'b0) begin
            m_rd  = (rd_n === 1'b0);
            m_cnt = model_lat;
        end
        sdram_busy = model_hold || (m_cnt > 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ack(input bit for_cpu, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (for_cpu ? cpu_ack : video_ack) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        int   n, first, nv, nc, vb, g, dbl;
        bit   ok;
        int   order [3];

        reset_n = 1'b0; sdram_init_busy = 1'b1;
        video_req = 1'b0; video_address = '0;
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_address = '0; cpu_wdata = '0;
        repeat (2) @(posedge clk); #1;

        check("rst_mreq_n", mreq_n, 1);
        check("rst_rd_n", rd_n, 1);
        check("rst_wr_n", wr_n, 1);
        check("rst_rfsh_n", rfsh_n, 1);
        check("rst_address", address, 0);
        check("rst_wdata", wdata, 0);
        check("rst_acks", {video_ack, cpu_ack}, 0);
        check("rst_rdata_en", {video_rdata_en, cpu_rdata_en}, 0);
        check("rst_video_rdata", video_rdata, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);

        // Init busy blocks grants and refresh for 100 clocks.
        reset_n = 1'b1; video_req = 1'b1;
        n = 0;
        repeat (100) begin
            @(posedge clk); #1;
            if (!mreq_n || !rfsh_n || video_ack) n++;
        end
        check("init_blocks", n, 0);
        video_req = 1'b0; sdram_init_busy = 1'b0; rel0 = cyc;

        first = 0;
        for (int i = 1; i <= 400; i++) begin
            @(posedge clk); #1;
            if (!rfsh_n) begin
                first = i;
                break;
            end
        end
        check("rfsh_first_spacing", (first == 320 || first == 321), 1);
        check("rfsh_mreq_n", mreq_n, 0);
        check("rfsh_rd_wr_n", {rd_n, wr_n}, 2'b11);
        repeat (6) @(posedge clk); #1;

        // Video read.
        model_rdata = 32'hDEADBEEF; video_address = 23'h000100; video_req = 1'b1;
        wait_ack(1'b0, ok);
        check("vid_ack_seen", ok, 1);
        check("vid_mreq_n", mreq_n, 0);
        check("vid_rd_n", rd_n, 0);
        check("vid_wr_rfsh_n", {wr_n, rfsh_n}, 2'b11);
        check("vid_address", address, 32'h100);
        check("vid_no_cpu_ack", cpu_ack, 0);
        video_req = 1'b0;
        @(posedge clk); #1;
        check("vid_ack_one_cycle", video_ack, 0);
        check("vid_mreq_release", mreq_n, 1);
        @(posedge clk); #1;
        check("vid_en_early", video_rdata_en, 0);
        @(posedge clk); #1;
        check("vid_en", video_rdata_en, 1);
        check("vid_rdata", video_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        check("vid_en_pulse", video_rdata_en, 0);

        // CPU read of byte lane 2.
        model_rdata = 32'h44332211; cpu_address = 23'h000102; cpu_wr = 1'b0; cpu_req = 1'b1;
        wait_ack(1'b1, ok);
        check("cpurd_ack_seen", ok, 1);
        check("cpurd_rd_n", rd_n, 0);
        check("cpurd_address", address, 32'h102);
        cpu_req = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("cpurd_en", cpu_rdata_en, 1);
        check("cpurd_byte", cpu_rdata, 32'h33);
        check("cpurd_no_video_en", video_rdata_en, 0);
        @(posedge clk); #1;

        // CPU write.
        cpu_address = 23'h000005; cpu_wdata = 8'hA5; cpu_wr = 1'b1; cpu_req = 1'b1;
        wait_ack(1'b1, ok);
        check("cpuwr_ack_seen", ok, 1);
        check("cpuwr_wr_n", wr_n, 0);
        check("cpuwr_rd_n", rd_n, 1);
        check("cpuwr_address", address, 32'h5);
        check("cpuwr_wdata", wdata, 32'hA5);
        cpu_req = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h00;
        n = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (cpu_rdata_en) n++;
        end
        check("cpuwr_no_rdata_en", n, 0);
        check("cpuwr_addr_hold", address, 32'h5);
        check("cpuwr_wdata_hold", wdata, 32'hA5);

        // Refresh, video and CPU all pending in the same cycle.
        model_hold = 1'b1;
        video_address = 23'h000200; video_req = 1'b1;
        cpu_address = 23'h000300; cpu_wr = 1'b0; cpu_req = 1'b1;
        n = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (video_ack || cpu_ack || !mreq_n) n++;
        end
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            if (video_ack || cpu_ack || !mreq_n) n++;
            if ((cyc - rel0) % 320 == 5) break;
        end
        check("busy_blocks_grant", n, 0);
        model_hold = 1'b0;
        g = 0; dbl = 0;
        order[0] = 0; order[1] = 0; order[2] = 0;
        for (int i = 0; i < 80 && g < 3; i++) begin
            @(posedge clk); #1;
            if (video_ack && cpu_ack) dbl++;
            if (!mreq_n) begin
                order[g] = !rfsh_n ? 1 : (video_ack ? 2 : (cpu_ack ? 3 : 0));
                g++;
            end
            if (video_ack) video_req = 1'b0;
            if (cpu_ack)   cpu_req   = 1'b0;
        end
        check("prio_first_refresh", order[0], 1);
        check("prio_second_video", order[1], 2);
        check("prio_third_cpu", order[2], 3);
        check("prio_no_double_ack", dbl, 0);
        repeat (6) @(posedge clk); #1;

        // Continuous video plus CPU requests.
        video_address = 23'h000400; video_req = 1'b1;
        cpu_address = 23'h000401; cpu_wr = 1'b0; cpu_req = 1'b1;
        nv = 0; nc = 0; vb = -1;
        repeat (1000) begin
            @(posedge clk); #1;
            if (video_ack) nv++;
            if (cpu_ack) begin
                if (nc == 0) vb = nv;
                nc++;
            end
        end
`ifdef SDRAM_ARB_CPU_FAIR_EN
        check("fair_cpu_granted", (nc > 0), 1);
        check("fair_after_one_video", vb, 1);
`else
        check("strict_cpu_starved", nc, 0);
        check("strict_video_runs", (nv >= 100), 1);
`endif
        video_req = 1'b0; cpu_req = 1'b0;
        repeat (8) @(posedge clk); #1;

        // Reset during S_WAIT of a video read.
        model_lat = 4; model_rdata = 32'hCAFEF00D;
        video_address = 23'h000500; video_req = 1'b1;
        wait_ack(1'b0, ok);
        check("abort_ack_seen", ok, 1);
        video_req = 1'b0; model_hold = 1'b1;
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("abort_strobes_high", {mreq_n, rd_n, wr_n, rfsh_n}, 4'b1111);
        reset_n = 1'b1;
        n = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (video_rdata_en || cpu_rdata_en || video_ack || cpu_ack) n++;
        end
        check("abort_no_rdata_en", n, 0);
        check("abort_video_rdata", video_rdata, 0);
        model_hold = 1'b0; model_lat = 2;
        repeat (4) @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
